// File: rtl/arp_pkg.sv
// ============================================================================
//  Module      : arp_pkg
//  Description : Shared ARP constants, frame field lengths and TX state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE     = 16'h0001;
    localparam logic [15:0] ARP_PTYPE     = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REP    = 16'h0002;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [7:0]  PREAMBLE_LEN  = 8'd8;
    localparam logic [7:0]  ETH_HEAD_LEN  = 8'd14;
    localparam logic [7:0]  ARP_DATA_LEN  = 8'd28;
    localparam logic [7:0]  PAD_LEN       = 8'd18;
    localparam logic [7:0]  FCS_LEN       = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH_HEAD = 3'd2,
        ST_ARP_DATA = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } arp_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/crc32_d8.sv
// ============================================================================
//  Module      : crc32_d8
//  Description : Byte-wide CRC-32 (poly 04C11DB7, data LSB first), MSB-first register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_d8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_en,
    input  logic        crc_clr,
    input  logic [7:0]  data,
    output logic [31:0] crc_data,
    output logic [31:0] crc_next
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    always_comb begin
        crc_next = crc_data;
        for (int i = 0; i < 8; i++) begin
            crc_next = {crc_next[30:0], 1'b0} ^ ((crc_next[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_data <= CRC_INIT;
        end else if (crc_clr) begin
            crc_data <= CRC_INIT;
        end else if (crc_en) begin
            crc_data <= crc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/arp_tx.sv
// ============================================================================
//  Module      : arp_tx
//  Description : GMII ARP request/reply frame transmitter with FCS and IFG.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

    arp_tx_state_e     state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              type_q;
    logic [47:0]       des_mac_q;
    logic [31:0]       des_ip_q;

    logic              w_accept;
    logic              w_crc_en;
    logic [7:0]        w_txd_d;
    logic              w_tx_en_d, w_done_d, w_busy_d;
    logic [31:0]       w_crc_q, w_crc_next, w_fcs;
    logic [0:13][7:0]  w_eth;
    logic [0:27][7:0]  w_arp;

    assign w_accept = (state_q == ST_IDLE) && arp_tx_en;

    assign w_eth = {type_q ? des_mac_q : DES_MAC, BOARD_MAC, ETH_TYPE_ARP};
    assign w_arp = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN,
                    type_q ? ARP_OP_REP : ARP_OP_REQ,
                    BOARD_MAC, BOARD_IP,
                    type_q ? des_mac_q : 48'h0, des_ip_q};

    // Register holds the non-reflected CRC; wire order needs bit reversal plus complement.
    for (genvar i = 0; i < 32; i++) begin : g_fcs_rev
        assign w_fcs[i] = ~w_crc_q[31-i];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arp_tx_en) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: if (cnt_q == PREAMBLE_LEN - 8'd1) begin state_d = ST_ETH_HEAD; cnt_d = '0; end
            ST_ETH_HEAD: if (cnt_q == ETH_HEAD_LEN - 8'd1) begin state_d = ST_ARP_DATA; cnt_d = '0; end
            ST_ARP_DATA: if (cnt_q == ARP_DATA_LEN - 8'd1) begin state_d = ST_PAD;      cnt_d = '0; end
            ST_PAD:      if (cnt_q == PAD_LEN - 8'd1)      begin state_d = ST_FCS;      cnt_d = '0; end
            ST_FCS:      if (cnt_q == FCS_LEN - 8'd1)      begin state_d = ST_IFG;      cnt_d = '0; end
            ST_IFG:      if (cnt_q == IFG_LAST)            begin state_d = ST_IDLE;     cnt_d = '0; end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The byte for the upcoming position is chosen here and registered onto the pins.
    always_comb begin
        w_txd_d = 8'h00;
        case (state_d)
            ST_PREAMBLE: w_txd_d = (cnt_d == PREAMBLE_LEN - 8'd1) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_ETH_HEAD: w_txd_d = w_eth[cnt_d[3:0]];
            ST_ARP_DATA: w_txd_d = w_arp[cnt_d[4:0]];
            ST_FCS:      w_txd_d = w_fcs[{cnt_d[1:0], 3'b000} +: 8];
            default:     w_txd_d = 8'h00;
        endcase
    end

    assign w_crc_en  = (state_d == ST_ETH_HEAD) || (state_d == ST_ARP_DATA) || (state_d == ST_PAD);
    assign w_tx_en_d = (state_d != ST_IDLE) && (state_d != ST_IFG);
    assign w_done_d  = (state_q == ST_FCS) && (state_d == ST_IFG);
    assign w_busy_d  = (state_d != ST_IDLE);

    crc32_d8 u_crc32_d8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .crc_en   (w_crc_en),
        .crc_clr  (w_accept),
        .data     (w_txd_d),
        .crc_data (w_crc_q),
        .crc_next (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            type_q     <= 1'b0;
            des_mac_q  <= '0;
            des_ip_q   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_done    <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gmii_tx_en <= w_tx_en_d;
            gmii_txd   <= w_txd_d;
            tx_done    <= w_done_d;
            tx_busy    <= w_busy_d;
            if (w_accept) begin
                type_q    <= arp_tx_type;
                des_mac_q <= des_mac;
                des_ip_q  <= des_ip;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arp_tx.sv
// ============================================================================
//  Module      : tb_arp_tx
//  Description : Self-checking bench for arp_tx against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arp_tx;

    localparam logic [47:0] C_BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] C_BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [47:0] C_DES_MAC   = 48'hff_ff_ff_ff_ff_ff;
    localparam int          C_IFG       = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        tx_busy, tx_done, gmii_tx_en;
    logic [7:0]  gmii_txd;

    int n_cmp  = 0;
    int n_fail = 0;

    arp_tx #(
        .BOARD_MAC  (C_BOARD_MAC),
        .BOARD_IP   (C_BOARD_IP),
        .DES_MAC    (C_DES_MAC),
        .IFG_CYCLES (C_IFG)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reflected (LSB-first) CRC-32 byte update, the textbook Ethernet form.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    // Whole frame (preamble through FCS) laid out from the field rules; returns byte idx.
    function automatic logic [7:0] frame_byte(input bit typ, input logic [47:0] mac,
                                              input logic [31:0] ip, input int idx);
        logic [7:0]  f [72];
        logic [47:0] dmac, tmac, bm;
        logic [31:0] bi, c;
        bm   = C_BOARD_MAC;
        bi   = C_BOARD_IP;
        dmac = typ ? mac : C_DES_MAC;
        tmac = typ ? mac : 48'h0;
        for (int i = 0; i < 72; i++) f[i] = 8'h00;
        for (int i = 0; i < 7; i++)  f[i] = 8'h55;
        f[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            f[8+i]  = dmac[47-8*i -: 8];
            f[14+i] = bm[47-8*i -: 8];
            f[30+i] = bm[47-8*i -: 8];
            f[40+i] = tmac[47-8*i -: 8];
        end
        f[20] = 8'h08; f[21] = 8'h06;
        f[22] = 8'h00; f[23] = 8'h01; f[24] = 8'h08; f[25] = 8'h00;
        f[26] = 8'h06; f[27] = 8'h04; f[28] = 8'h00; f[29] = typ ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            f[36+i] = bi[31-8*i -: 8];
            f[46+i] = ip[31-8*i -: 8];
        end
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) c = crc_byte(c, f[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) f[68+k] = c[8*k +: 8];
        return f[idx];
    endfunction

    // Model: m_pos = cycles since acceptance (1..72 data, 73 done), -1 when idle.
    int          m_pos;
    bit          m_typ;
    logic [47:0] m_mac;
    logic [31:0] m_ip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= -1;
        end else if (m_pos < 0) begin
            if (arp_tx_en) begin
                m_pos <= 1;
                m_typ <= arp_tx_type;
                m_mac <= des_mac;
                m_ip  <= des_ip;
            end
        end else if (m_pos + 1 == 73 + C_IFG) begin
            m_pos <= -1;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    bit check_on = 1'b0;

    always @(negedge clk) begin
        if (check_on && rst_n) begin
            logic       e_en, e_done, e_busy;
            logic [7:0] e_txd;
            e_en   = (m_pos >= 1) && (m_pos <= 72);
            e_txd  = e_en ? frame_byte(m_typ, m_mac, m_ip, m_pos - 1) : 8'h00;
            e_done = (m_pos == 73);
            e_busy = (m_pos >= 1);
            check($sformatf("outputs{en,txd,done,busy}@pos%0d", m_pos),
                  {gmii_tx_en, gmii_txd, tx_done, tx_busy},
                  {e_en, e_txd, e_done, e_busy});
        end
    end

    // Independent capture of what actually went out on the wire.
    int         cyc = 0;
    logic [7:0] cap [$];
    int         starts [$];
    int         dones [$];
    int         n_done = 0;
    logic       prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap.delete();
            prev_en = 1'b0;
        end else begin
            if (gmii_tx_en && !prev_en) starts.push_back(cyc);
            prev_en = gmii_tx_en;
            if (gmii_tx_en) cap.push_back(gmii_txd);
            if (tx_done) begin
                logic [31:0] c;
                dones.push_back(cyc);
                n_done++;
                check("frame_len", 64'(cap.size()), 64'd72);
                if (cap.size() == 72) begin
                    c = 32'hFFFF_FFFF;
                    for (int i = 8; i < 72; i++) c = crc_byte(c, cap[i]);
                    check("fcs_residue", {32'h0, bitrev32(c)}, 64'hC704_DD7B);
                end
                cap.delete();
            end
        end
    end

    initial begin
        int          c0, d0;
        logic [31:0] c;
        logic [31:0] req_ip;
        req_ip      = {8'd192, 8'd168, 8'd1, 8'd102};
        rst_n       = 1'b0;
        arp_tx_en   = 1'b0;
        arp_tx_type = 1'b0;
        des_mac     = 48'h0;
        des_ip      = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_gmii_tx_en", {63'h0, gmii_tx_en}, 64'h0);
        check("rst_gmii_txd",   {56'h0, gmii_txd},   64'h0);
        check("rst_tx_done",    {63'h0, tx_done},    64'h0);
        check("rst_tx_busy",    {63'h0, tx_busy},    64'h0);

        // Pin the model against hand-known values.
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = crc_byte(c, 8'h31 + 8'(i));
        check("model_crc_123456789", {32'h0, ~c}, 64'hCBF4_3926);
        check("model_req_sfd",   {56'h0, frame_byte(0, 48'h0, req_ip, 7)},  64'hD5);
        check("model_req_dmac",  {56'h0, frame_byte(0, 48'h0, req_ip, 8)},  64'hFF);
        check("model_req_etype", {56'h0, frame_byte(0, 48'h0, req_ip, 21)}, 64'h06);
        check("model_req_op",    {56'h0, frame_byte(0, 48'h0, req_ip, 29)}, 64'h01);
        check("model_req_tip3",  {56'h0, frame_byte(0, 48'h0, req_ip, 49)}, 64'h66);
        check("model_rep_op",    {56'h0, frame_byte(1, 48'h0A0B0C0D0E0F, req_ip, 29)}, 64'h02);
        check("model_rep_tmac",  {56'h0, frame_byte(1, 48'h0A0B0C0D0E0F, req_ip, 45)}, 64'h0F);

        rst_n    = 1'b1;
        check_on = 1'b1;

        // Request frame.
        @(negedge clk);
        starts.delete(); dones.delete();
        c0 = cyc;
        arp_tx_type = 1'b0; des_mac = 48'h0A0B0C0D0E0F; des_ip = req_ip; arp_tx_en = 1'b1;
        @(negedge clk); arp_tx_en = 1'b0;
        repeat (100) @(negedge clk);
        check("req_start_cycle", 64'(starts.size() > 0 ? starts[0] - c0 : -1), 64'd1);
        check("req_done_cycle",  64'(dones.size()  > 0 ? dones[0]  - c0 : -1), 64'd73);

        // Reply, inputs changed at cycle 5, start pulses at 30, 80 (ignored) and 85.
        starts.delete(); dones.delete();
        c0 = cyc;
        arp_tx_type = 1'b1; des_mac = 48'h0A0B0C0D0E0F;
        des_ip = {8'd192, 8'd168, 8'd1, 8'd200}; arp_tx_en = 1'b1;
        @(negedge clk); arp_tx_en = 1'b0;
        repeat (4) @(negedge clk);
        des_mac = 48'hDEAD_BEEF_0001; des_ip = 32'h0102_0304;
        repeat (25) @(negedge clk); arp_tx_en = 1'b1;
        @(negedge clk);             arp_tx_en = 1'b0;
        repeat (49) @(negedge clk); arp_tx_en = 1'b1;
        @(negedge clk);             arp_tx_en = 1'b0;
        repeat (4) @(negedge clk);  arp_tx_en = 1'b1;
        @(negedge clk);             arp_tx_en = 1'b0;
        repeat (100) @(negedge clk);
        check("busy_frame_count", 64'(starts.size()), 64'd2);
        check("busy_second_start", 64'(starts.size() > 1 ? starts[1] - c0 : -1), 64'd86);

        // Reset in the middle of a frame.
        d0 = n_done;
        arp_tx_type = 1'b0; des_ip = req_ip; arp_tx_en = 1'b1;
        @(negedge clk); arp_tx_en = 1'b0;
        repeat (39) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx_en_async", {63'h0, gmii_tx_en}, 64'h0);
        check("abort_busy_async",  {63'h0, tx_busy},    64'h0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        arp_tx_en = 1'b1;
        @(negedge clk); arp_tx_en = 1'b0;
        repeat (100) @(negedge clk);
        check("after_abort_frames", 64'(n_done - d0), 64'd1);

        // Back-to-back with start held high.
        starts.delete();
        c0 = cyc;
        arp_tx_type = 1'b1; des_mac = 48'h0A0B0C0D0E0F; arp_tx_en = 1'b1;
        repeat (175) @(negedge clk);
        arp_tx_en = 1'b0;
        repeat (100) @(negedge clk);
        check("b2b_frame_count", 64'(starts.size()), 64'd3);
        if (starts.size() == 3) begin
            check("b2b_start0", 64'(starts[0] - c0), 64'd1);
            check("b2b_start1", 64'(starts[1] - c0), 64'd86);
            check("b2b_start2", 64'(starts[2] - c0), 64'd171);
        end

        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
